byte_lsu: RTL and testbench

Load/store unit that sits between the CPU datapath and the byte-wide data RAM and acts as the initiator on the RAM port. It accepts one byte, halfword or word request at a time and serializes it into single-byte RAM accesses, one per cycle, in big-endian order. Loads are reassembled, then zero- or sign-extended. Misaligned or illegal requests complete immediately with an error flag and touch no memory.

---
 rtl/byte_lsu.sv | 155 +++++++++++++++
 tb/tb_byte_lsu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/byte_lsu.sv
// Byte-serial load/store unit: splits byte/half/word requests into
// big-endian single-byte RAM accesses and reassembles/extends loads.
module byte_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wd,
    output logic              mem_we,
    input  logic [7:0]        mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        k_q, k_d;
    logic [31:0]       acc_q, acc_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic        bad;
    logic [1:0]  last;
    logic [1:0]  idx;
    logic [31:0] acc_nx;
    logic [31:0] ext;
    logic [7:0]  wbyte;

    assign bad = (size == 2'b11)
              || (size == 2'b01 && addr[0])
              || (size == 2'b10 && addr[1:0] != 2'b00);

    assign acc_nx = {acc_q[23:0], mem_rd};
    assign idx    = last - k_q;

    always_comb begin
        last = 2'd0;
        unique case (size_q)
            2'b01:   last = 2'd1;
            2'b10:   last = 2'd3;
            default: last = 2'd0;
        endcase
    end

    // Most significant byte of the access goes out first.
    always_comb begin
        wbyte = 8'h00;
        unique case (idx)
            2'd0: wbyte = wdata_q[7:0];
            2'd1: wbyte = wdata_q[15:8];
            2'd2: wbyte = wdata_q[23:16];
            2'd3: wbyte = wdata_q[31:24];
        endcase
    end

    always_comb begin
        ext = acc_nx;
        unique case (size_q)
            2'b00: ext = uns_q ? {24'h0, acc_nx[7:0]}
                               : {{24{acc_nx[7]}}, acc_nx[7:0]};
            2'b01: ext = uns_q ? {16'h0, acc_nx[15:0]}
                               : {{16{acc_nx[15]}}, acc_nx[15:0]};
            default: ext = acc_nx;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        k_d     = k_q;
        acc_d   = acc_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    size_d  = size;
                    uns_d   = uns;
                    wdata_d = wdata;
                    k_d     = 2'd0;
                    acc_d   = 32'h0;
                    err_d   = bad;
                    state_d = bad ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) acc_d = acc_nx;
                if (k_q == last) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = ext;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
            k_q     <= 2'd0;
            acc_q   <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready    = (state_q == IDLE);
    assign done     = (state_q == DONE);
    assign err      = done & err_q;
    assign rdata    = rdata_q;
    assign mem_we   = (state_q == ACCESS) & we_q;
    assign mem_addr = (state_q == ACCESS) ? addr_q + ADDR_W'(k_q) : '0;
    assign mem_wd   = mem_we ? wbyte : 8'h00;

endmodule

// File: tb/tb_byte_lsu.sv
// Scoreboard bench for byte_lsu with a 256-byte behavioural RAM.
module tb_byte_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        ready, done, err;
    logic [31:0] rdata, mem_addr;
    logic [7:0]  mem_wd, mem_rd;
    logic        mem_we;

    logic [7:0] ram [256];

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          lat;
    } exp_t;

    exp_t q[$];
    exp_t e;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n_acc = 0;
    int wr_cnt = 0;
    int w24 = 0;
    int nz_cnt = 0;

    byte_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we),
        .size(size), .uns(uns), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .err(err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
        .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = ram[mem_addr[7:0]];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr[7:0]] = mem_wd;
            wr_cnt = wr_cnt + 1;
            if (mem_addr == 32'h24) w24 = w24 + 1;
        end
        if (mem_addr != 32'h0) nz_cnt = nz_cnt + 1;
        if (rst_n && req && ready) begin
            acc_cyc = cyc;
            n_acc = n_acc + 1;
        end
        cyc = cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("rdata", rdata, e.rd);
                chk("err", {31'h0, err}, {31'h0, e.er});
                chk("latency", cyc - acc_cyc, e.lat);
                chk("ready_in_done", {31'h0, ready}, 32'd0);
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (q.size() != 0) begin
            chk("done_timeout", q.size(), 32'd0);
            q.delete();
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] s,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd,
                         input logic er, input int lat);
        wait_ready();
        req = 1'b1; we = w; size = s; uns = u;
        addr = a; wdata = d;
        q.push_back('{rd: rd, er: er, lat: lat});
        @(negedge clk);
        req = 1'b0;
        drain();
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, {31'h0, ready}, 32'd1);
        chk({tag, "_done"}, {31'h0, done}, 32'd0);
        chk({tag, "_err"}, {31'h0, err}, 32'd0);
        chk({tag, "_rdata"}, rdata, 32'd0);
        chk({tag, "_mem_we"}, {31'h0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wd"}, {24'h0, mem_wd}, 32'd0);
    endtask

    initial begin
        int w0, a0, z0;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; uns = 1'b0;
        size = 2'b00; addr = 32'h0; wdata = 32'h0;
        #1;
        chk_reset_outs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 5);
        chk("ram10", {24'h0, ram[8'h10]}, 32'h11);
        chk("ram11", {24'h0, ram[8'h11]}, 32'h22);
        chk("ram12", {24'h0, ram[8'h12]}, 32'h33);
        chk("ram13", {24'h0, ram[8'h13]}, 32'h44);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h11223344, 1'b0, 5);

        ram[8'h20] = 8'h80;
        issue(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 2);
        issue(1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 32'h00000080, 1'b0, 2);

        issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234BEEF, 32'h80, 1'b0, 3);
        chk("ram22", {24'h0, ram[8'h22]}, 32'hBE);
        chk("ram23", {24'h0, ram[8'h23]}, 32'hEF);
        chk("no_we_24", w24, 32'd0);
        issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFFBEEF, 1'b0, 3);
        issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h0000BEEF, 1'b0, 3);

        w0 = wr_cnt;
        issue(1'b1, 2'b10, 1'b0, 32'h31, 32'hDEADBEEF, 32'h0000BEEF, 1'b1, 1);
        issue(1'b1, 2'b11, 1'b0, 32'h30, 32'hDEADBEEF, 32'h0000BEEF, 1'b1, 1);
        issue(1'b0, 2'b01, 1'b0, 32'h23, 32'h0, 32'h0000BEEF, 1'b1, 1);
        chk("err_no_writes", wr_cnt - w0, 32'd0);
        chk("ram31", {24'h0, ram[8'h31]}, 32'h00);

        wait_ready();
        a0 = n_acc; z0 = nz_cnt;
        req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0;
        addr = 32'h10; wdata = 32'h0;
        q.push_back('{rd: 32'h11223344, er: 1'b0, lat: 5});
        q.push_back('{rd: 32'h11223344, er: 1'b0, lat: 5});
        repeat (7) @(negedge clk);
        req = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        chk("held_accepts", n_acc - a0, 32'd2);
        chk("held_access_cycles", nz_cnt - z0, 32'd8);

        wait_ready();
        req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0;
        addr = 32'h40; wdata = 32'hAABBCCDD;
        @(negedge clk);
        req = 1'b0;
        repeat (2) @(negedge clk);
        chk("k2_addr", mem_addr, 32'h42);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("mid");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, ready}, 32'd1);
        chk("ram40", {24'h0, ram[8'h40]}, 32'hAA);
        chk("ram41", {24'h0, ram[8'h41]}, 32'hBB);
        chk("ram42", {24'h0, ram[8'h42]}, 32'h00);
        chk("ram43", {24'h0, ram[8'h43]}, 32'h00);

        issue(1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 32'h000000BB, 1'b0, 2);
        issue(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, 32'hFFFFFFAA, 1'b0, 2);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
